// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_serializer
//  Description : Width down-converter. Pops one wide word (width_p*ratio_p
//                bits) from an upstream ready/valid source and replays it as
//                len+1 narrow beats of width_p bits, least-significant slice
//                first, on a ready/valid output. The last beat of a word and
//                the first beat of the next leave on consecutive cycles.
//
//  Ports       : clk_i      - clock
//                reset_ni   - asynchronous active-low reset
//                data_i     - input word, beat k = data_i[k*width_p +: width_p]
//                len_i      - beats in word minus one (clamped to ratio_p-1)
//                valid_i    - input word valid
//                ready_o    - block can accept a word this cycle
//                data_o     - current output beat
//                last_o     - current beat is the final beat of its word
//                valid_o    - output beat valid
//                ready_i    - downstream accepts the beat
//
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_serializer #(
    parameter int width_p = 8,
    parameter int ratio_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [width_p*ratio_p-1:0]   data_i,
    input  logic [$clog2(ratio_p)-1:0]   len_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [width_p-1:0]           data_o,
    output logic                         last_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    localparam int c_LEN_W  = $clog2(ratio_p);
    localparam int c_WORD_W = width_p * ratio_p;

    localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(ratio_p - 1);

    // Two-state machine, the state register doubles as the occupancy flag.
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_HOLD  = 1'b1;

    logic [c_WORD_W-1:0] r_word;
    logic [c_LEN_W-1:0]  r_beat;
    logic [c_LEN_W-1:0]  r_len;
    logic [0:0]          r_full;

    logic                w_last;
    logic                w_in_acc;
    logic                w_out_acc;
    logic [c_LEN_W-1:0]  w_len_clamped;

    // When ratio_p is not a power of two the length field can encode more
    // beats than a word holds; those lengths saturate to the full word.
    always_comb begin
        w_len_clamped = len_i;
        if (len_i > c_LEN_MAX) begin
            w_len_clamped = c_LEN_MAX;
        end
    end

    assign w_last    = (r_full == c_HOLD) && (r_beat == r_len);
    assign valid_o   = (r_full == c_HOLD);
    assign last_o    = w_last;
    // Accept a new word either when idle or while the final beat of the
    // current word is being taken, which keeps the output stream gap-free.
    assign ready_o   = (r_full == c_EMPTY) || (ready_i && w_last);
    assign w_in_acc  = valid_i && ready_o;
    assign w_out_acc = valid_o && ready_i;

    assign data_o    = r_word[int'(r_beat)*width_p +: width_p];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_word <= '0;
            r_beat <= '0;
            r_len  <= '0;
            r_full <= c_EMPTY;
        end else if (w_in_acc) begin
            // A load wins over the last-beat pop; the counter restarts at 0.
            r_word <= data_i;
            r_len  <= w_len_clamped;
            r_beat <= '0;
            r_full <= c_HOLD;
        end else if (w_out_acc) begin
            if (w_last) begin
                r_full <= c_EMPTY;
                r_beat <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_serializer
//  Description : Self-checking bench for stream_serializer. Two instances
//                (ratio 4 and ratio 3) are fed from FIFO-like word queues;
//                a queue of expected beats per instance predicts the output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  l;
    } word_t;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } beat_t;

    logic        clk_i;
    logic        reset_ni;
    logic        ready_i;

    logic [31:0] d4;
    logic [1:0]  l4;
    logic        v4;
    logic        rdy4;
    logic [7:0]  q4;
    logic        last4;
    logic        vo4;

    logic [23:0] d3;
    logic [1:0]  l3;
    logic        v3;
    logic        rdy3;
    logic [7:0]  q3;
    logic        last3;
    logic        vo3;

    int checks   = 0;
    int failures = 0;

    word_t src4[$];
    word_t src3[$];
    beat_t exp4[$];
    beat_t exp3[$];

    stream_serializer #(.width_p(8), .ratio_p(4)) dut4 (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .data_i   (d4),
        .len_i    (l4),
        .valid_i  (v4),
        .ready_o  (rdy4),
        .data_o   (q4),
        .last_o   (last4),
        .valid_o  (vo4),
        .ready_i  (ready_i)
    );

    stream_serializer #(.width_p(8), .ratio_p(3)) dut3 (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .data_i   (d3),
        .len_i    (l3),
        .valid_i  (v3),
        .ready_o  (rdy3),
        .data_o   (q3),
        .last_o   (last3),
        .valid_o  (vo3),
        .ready_i  (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present inputs, check outputs mid-cycle, then advance
    // the reference model at the rising edge. Entered and left at posedge+1.
    task automatic cycle(input logic rdy, input logic gate);
        logic e_rdy4, e_rdy3, acc4, acc3;
        int   n;
        word_t w;
        ready_i = rdy;
        v4 = gate && (src4.size() != 0);
        v3 = gate && (src3.size() != 0);
        if (v4) begin d4 = src4[0].d; l4 = src4[0].l; end
        else    begin d4 = $urandom; l4 = 2'($urandom); end
        if (v3) begin d3 = src3[0].d[23:0]; l3 = src3[0].l; end
        else    begin d3 = 24'($urandom); l3 = 2'($urandom); end
        #3;
        e_rdy4 = (exp4.size() == 0) || (exp4.size() == 1 && rdy);
        e_rdy3 = (exp3.size() == 0) || (exp3.size() == 1 && rdy);
        chk("r4_valid", 32'(vo4),  32'(exp4.size() != 0));
        chk("r4_ready", 32'(rdy4), 32'(e_rdy4));
        chk("r4_last",  32'(last4), (exp4.size() != 0) ? 32'(exp4[0].last) : 32'd0);
        if (exp4.size() != 0) chk("r4_data", 32'(q4), 32'(exp4[0].d));
        chk("r3_valid", 32'(vo3),  32'(exp3.size() != 0));
        chk("r3_ready", 32'(rdy3), 32'(e_rdy3));
        chk("r3_last",  32'(last3), (exp3.size() != 0) ? 32'(exp3[0].last) : 32'd0);
        if (exp3.size() != 0) chk("r3_data", 32'(q3), 32'(exp3[0].d));
        acc4 = v4 && e_rdy4;
        acc3 = v3 && e_rdy3;
        @(posedge clk_i);
        if (rdy && exp4.size() != 0) void'(exp4.pop_front());
        if (rdy && exp3.size() != 0) void'(exp3.pop_front());
        if (acc4) begin
            w = src4.pop_front();
            n = int'(w.l) + 1;
            for (int k = 0; k < n; k++)
                exp4.push_back('{d: w.d[k*8 +: 8], last: (k == n-1)});
        end
        if (acc3) begin
            w = src3.pop_front();
            n = (int'(w.l) > 2 ? 2 : int'(w.l)) + 1;
            for (int k = 0; k < n; k++)
                exp3.push_back('{d: w.d[k*8 +: 8], last: (k == n-1)});
        end
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst4_valid", 32'(vo4),   32'd0);
        chk("rst4_last",  32'(last4), 32'd0);
        chk("rst4_data",  32'(q4),    32'd0);
        chk("rst4_ready", 32'(rdy4),  32'd1);
        chk("rst3_valid", 32'(vo3),   32'd0);
        chk("rst3_ready", 32'(rdy3),  32'd1);
    endtask

    initial begin
        int guard;
        reset_ni = 1'b0;
        ready_i  = 1'b1;
        v4 = 1'b0; d4 = '0; l4 = '0;
        v3 = 1'b0; d3 = '0; l3 = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs();
        reset_ni = 1'b1;

        // Full word, no stalls.
        src4.push_back('{d: 32'hDDCCBBAA, l: 2'd3});
        repeat (6) cycle(1'b1, 1'b1);

        // Back-to-back words, second has two beats.
        src4.push_back('{d: 32'h44332211, l: 2'd3});
        src4.push_back('{d: 32'h00008765, l: 2'd1});
        repeat (8) cycle(1'b1, 1'b1);

        // Backpressure for three cycles on beat BB.
        src4.push_back('{d: 32'hDDCCBBAA, l: 2'd3});
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        repeat (4) cycle(1'b1, 1'b1);

        // Ten single-beat words, one per cycle.
        for (int i = 1; i <= 10; i++) src4.push_back('{d: 32'(i), l: 2'd0});
        repeat (12) cycle(1'b1, 1'b1);

        // Length clamp on the ratio-3 instance: len 3 yields 3 beats.
        src3.push_back('{d: 32'h00CCBBAA, l: 2'd3});
        src3.push_back('{d: 32'h00332211, l: 2'd3});
        repeat (8) cycle(1'b1, 1'b1);

        // Reset asserted mid-word between clock edges.
        src4.push_back('{d: 32'h0D0C0B0A, l: 2'd3});
        src3.push_back('{d: 32'h000C0B0A, l: 2'd2});
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk_reset_outputs();
        src4.delete(); src3.delete(); exp4.delete(); exp3.delete();
        v4 = 1'b0; v3 = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        src4.push_back('{d: 32'hA4A3A2A1, l: 2'd2});
        repeat (5) cycle(1'b1, 1'b1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            if (src4.size() < 3) src4.push_back('{d: $urandom, l: 2'($urandom)});
            if (src3.size() < 3) src3.push_back('{d: {8'h00, 24'($urandom)}, l: 2'($urandom)});
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        // Drain with a bounded cycle budget.
        guard = 0;
        while ((src4.size() + src3.size() + exp4.size() + exp3.size()) != 0 && guard < 100) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        chk("drain_timeout", 32'(guard < 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
